// File: rtl/mc_datapath_state.sv
// Architectural state and operand steering for the multi-cycle MIPS core:
// PC, IR, MDR, register file, A/B, ALUOut, plus the address and ALU operand muxes.
module mc_datapath_state #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemtoReg,
    input  logic        RegDst,
    input  logic        IorD,
    input  logic        PCSrc,
    input  logic        ALUSrcA,
    input  logic [1:0]  ALUSrcB,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic        branch,
    input  logic        RegWrite,
    input  logic [31:0] ALUResult,
    input  logic        Zero,
    input  logic [31:0] ReadData,
    output logic [31:0] Adr,
    output logic [31:0] WriteData,
    output logic [31:0] SrcA,
    output logic [31:0] SrcB,
    output logic [31:0] Instr,
    output logic [31:0] PC
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] aluout_q;
    logic [31:0] rf_q [NREGS];

    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  wr_addr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] wr_data;
    logic [31:0] sign_imm;
    logic        pc_en;

    assign rs_addr  = ir_q[25:21];
    assign rt_addr  = ir_q[20:16];
    assign wr_addr  = RegDst ? ir_q[15:11] : ir_q[20:16];
    assign wr_data  = MemtoReg ? mdr_q : aluout_q;
    assign sign_imm = {{16{ir_q[15]}}, ir_q[15:0]};

    // Reads are unbypassed: a same-edge write is not visible until the following cycle.
    assign rd1 = (rs_addr == 5'd0) ? 32'd0 : rf_q[rs_addr];
    assign rd2 = (rt_addr == 5'd0) ? 32'd0 : rf_q[rt_addr];

    assign pc_en = PCWrite | (branch & Zero);

    always_comb begin
        pc_d = pc_q;
        if (pc_en) begin
            pc_d = PCSrc ? aluout_q : ALUResult;
        end
    end

    always_comb begin
        ir_d = ir_q;
        if (IRWrite) begin
            ir_d = ReadData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= ReadData;
            a_q      <= rd1;
            b_q      <= rd2;
            aluout_q <= ALUResult;
        end
    end

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (RegWrite && (wr_addr != 5'd0)) begin
            rf_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        SrcB = b_q;
        case (ALUSrcB)
            2'b00:   SrcB = b_q;
            2'b01:   SrcB = 32'd4;
            2'b10:   SrcB = sign_imm;
            default: SrcB = {sign_imm[29:0], 2'b00};
        endcase
    end

    assign SrcA      = ALUSrcA ? a_q : pc_q;
    assign Adr       = IorD ? aluout_q : pc_q;
    assign WriteData = b_q;
    assign Instr     = ir_q;
    assign PC        = pc_q;

endmodule

// File: tb/tb_mc_datapath_state.sv
// Directed vector bench for mc_datapath_state: a table of control/data vectors
// with hand-computed outputs, followed by an asynchronous mid-operation reset sequence.
module tb_mc_datapath_state;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemtoReg = 1'b0, RegDst = 1'b0, IorD = 1'b0, PCSrc = 1'b0;
    logic        ALUSrcA = 1'b0;
    logic [1:0]  ALUSrcB = 2'b00;
    logic        IRWrite = 1'b0, PCWrite = 1'b0, branch = 1'b0, RegWrite = 1'b0;
    logic        Zero = 1'b0;
    logic [31:0] ReadData = 32'd0;
    logic [31:0] ALUResult;
    logic [31:0] Adr, WriteData, SrcA, SrcB, Instr, PC;

    // Bench ALU: either an adder on the DUT operands or a directly forced value.
    logic        alu_auto = 1'b0;
    logic [31:0] alu_val  = 32'd0;
    assign ALUResult = alu_auto ? (SrcA + SrcB) : alu_val;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc_datapath_state dut (
        .clk       (clk),
        .reset     (reset),
        .MemtoReg  (MemtoReg),
        .RegDst    (RegDst),
        .IorD      (IorD),
        .PCSrc     (PCSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .branch    (branch),
        .RegWrite  (RegWrite),
        .ALUResult (ALUResult),
        .Zero      (Zero),
        .ReadData  (ReadData),
        .Adr       (Adr),
        .WriteData (WriteData),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Instr     (Instr),
        .PC        (PC)
    );

    // ctrl = {MemtoReg, RegDst, IorD, PCSrc, ALUSrcA, ALUSrcB[1:0], IRWrite, PCWrite, branch, RegWrite, Zero}
    localparam logic [11:0] C_M2R  = 12'h800, C_RDST = 12'h400, C_IORD = 12'h200, C_PCSRC = 12'h100;
    localparam logic [11:0] C_SRCA = 12'h080, C_B4   = 12'h020, C_BIMM = 12'h040, C_BSH   = 12'h060;
    localparam logic [11:0] C_IRW  = 12'h010, C_PCW  = 12'h008, C_BR   = 12'h004, C_RW    = 12'h002;
    localparam logic [11:0] C_Z    = 12'h001;
    localparam logic [5:0]  M_PC = 6'h20, M_IN = 6'h10, M_SA = 6'h08, M_SB = 6'h04, M_AD = 6'h02, M_WD = 6'h01;

    typedef struct {
        bit          clk_en;
        logic [11:0] ctrl;
        logic [31:0] rdata;
        logic [31:0] aluval;
        bit          auto_alu;
        logic [5:0]  mask;
        logic [31:0] pc, instr, srca, srcb, adr, wd;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(bit c, logic [11:0] ctrl, logic [31:0] rd, logic [31:0] al, bit au,
                                logic [5:0] m, logic [31:0] pc, logic [31:0] ins, logic [31:0] sa,
                                logic [31:0] sb, logic [31:0] ad, logic [31:0] wd);
        vec_t v;
        v.clk_en = c; v.ctrl = ctrl; v.rdata = rd; v.aluval = al; v.auto_alu = au; v.mask = m;
        v.pc = pc; v.instr = ins; v.srca = sa; v.srcb = sb; v.adr = ad; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive_ctrl(input logic [11:0] c);
        {MemtoReg, RegDst, IorD, PCSrc, ALUSrcA, ALUSrcB, IRWrite, PCWrite, branch, RegWrite, Zero} = c;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            clk ctrl                      rdata         alu        au mask                       pc         instr         srca          srcb          adr        wd
        vecs[0]  = mk(0, 12'h000,                  32'h0,        32'h0,     0, 6'h3F,                      32'h0,  32'h0,        32'h0,        32'h0,        32'h0,   32'h0);
        vecs[1]  = mk(1, C_IRW|C_PCW|C_B4,         32'h2008_0005, 32'h0,    1, 6'h3F,                      32'h4,  32'h2008_0005, 32'h4,       32'h4,        32'h4,   32'h0);
        vecs[2]  = mk(1, C_IRW|C_BIMM,             32'h2008_8000, 32'h0,    0, M_PC|M_IN|M_SB,             32'h4,  32'h2008_8000, 32'h0,       32'hFFFF_8000, 32'h0,  32'h0);
        vecs[3]  = mk(0, C_BSH,                    32'h2008_8000, 32'h0,    0, M_SB,                       32'h0,  32'h0,        32'h0,        32'hFFFE_0000, 32'h0,  32'h0);
        vecs[4]  = mk(1, C_IORD,                   32'h2008_8000, 32'h5,    0, M_PC|M_AD,                  32'h4,  32'h0,        32'h0,        32'h0,        32'h5,   32'h0);
        vecs[5]  = mk(1, C_RW,                     32'h2008_8000, 32'h0,    0, M_IN|M_WD,                  32'h0,  32'h2008_8000, 32'h0,       32'h0,        32'h0,   32'h0);
        vecs[6]  = mk(1, C_IRW,                    32'h0108_0000, 32'h0,    0, M_IN|M_WD,                  32'h0,  32'h0108_0000, 32'h0,       32'h0,        32'h0,   32'h5);
        vecs[7]  = mk(1, C_SRCA,                   32'h0,        32'h0,     0, M_SA|M_WD,                  32'h0,  32'h0,        32'h5,        32'h0,        32'h0,   32'h5);
        vecs[8]  = mk(1, C_IRW,                    32'h0,        32'h7,     0, M_IN|M_WD,                  32'h0,  32'h0,        32'h0,        32'h0,        32'h0,   32'h5);
        vecs[9]  = mk(1, C_RW|C_SRCA,              32'h0,        32'h0,     0, M_SA|M_WD,                  32'h0,  32'h0,        32'h0,        32'h0,        32'h0,   32'h0);
        vecs[10] = mk(1, C_SRCA,                   32'h0,        32'h0,     0, M_PC|M_SA|M_WD,             32'h4,  32'h0,        32'h0,        32'h0,        32'h0,   32'h0);
        vecs[11] = mk(1, C_IRW,                    32'h0108_4800, 32'h0,    0, M_IN,                       32'h0,  32'h0108_4800, 32'h0,       32'h0,        32'h0,   32'h0);
        vecs[12] = mk(1, C_IORD,                   32'hDEAD_BEEF, 32'h100,  0, M_AD|M_WD,                  32'h0,  32'h0,        32'h0,        32'h0,        32'h100, 32'h5);
        vecs[13] = mk(1, C_RW|C_RDST|C_M2R,        32'hDEAD_BEEF, 32'h0,    0, M_WD,                       32'h0,  32'h0,        32'h0,        32'h0,        32'h0,   32'h5);
        vecs[14] = mk(1, C_IRW,                    32'h0120_0000, 32'h0,    0, M_IN|M_WD,                  32'h0,  32'h0120_0000, 32'h0,       32'h0,        32'h0,   32'h5);
        vecs[15] = mk(1, C_SRCA,                   32'h0,        32'h0,     0, M_SA|M_WD,                  32'h0,  32'h0,        32'hDEAD_BEEF, 32'h0,       32'h0,   32'h0);
        vecs[16] = mk(1, C_SRCA,                   32'h0,        32'h40,    0, M_PC,                       32'h4,  32'h0,        32'h0,        32'h0,        32'h0,   32'h0);
        vecs[17] = mk(1, C_BR|C_Z|C_PCSRC,         32'h0,        32'h40,    0, M_PC|M_AD,                  32'h40, 32'h0,        32'h0,        32'h0,        32'h40,  32'h0);
        vecs[18] = mk(1, C_BR|C_PCSRC,             32'h0,        32'h80,    0, M_PC,                       32'h40, 32'h0,        32'h0,        32'h0,        32'h0,   32'h0);
        vecs[19] = mk(1, C_PCW|C_BR|C_PCSRC,       32'h0,        32'h0,     0, M_PC,                       32'h80, 32'h0,        32'h0,        32'h0,        32'h0,   32'h0);
        vecs[20] = mk(1, C_PCW,                    32'h0,        32'h40,    0, M_PC|M_SA,                  32'h40, 32'h0,        32'h40,       32'h0,        32'h0,   32'h0);

        // Initial 5 ns reset pulse, released between clock edges.
        #2 reset = 1'b1;
        #5 reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive_ctrl(vecs[i].ctrl);
            ReadData = vecs[i].rdata;
            alu_val  = vecs[i].aluval;
            alu_auto = vecs[i].auto_alu;
            if (vecs[i].clk_en) begin
                @(posedge clk);
                #1;
            end else begin
                #1;
            end
            $display("vec %0d: PC=%h Instr=%h SrcA=%h SrcB=%h Adr=%h WriteData=%h", i, PC, Instr, SrcA, SrcB, Adr, WriteData);
            if (vecs[i].mask[5]) chk($sformatf("v%0d.PC", i),        PC,        vecs[i].pc);
            if (vecs[i].mask[4]) chk($sformatf("v%0d.Instr", i),     Instr,     vecs[i].instr);
            if (vecs[i].mask[3]) chk($sformatf("v%0d.SrcA", i),      SrcA,      vecs[i].srca);
            if (vecs[i].mask[2]) chk($sformatf("v%0d.SrcB", i),      SrcB,      vecs[i].srcb);
            if (vecs[i].mask[1]) chk($sformatf("v%0d.Adr", i),       Adr,       vecs[i].adr);
            if (vecs[i].mask[0]) chk($sformatf("v%0d.WriteData", i), WriteData, vecs[i].wd);
        end

        // Mid-operation reset: PC=0x40, A holds $9 = DEADBEEF, IR nonzero.
        @(negedge clk);
        drive_ctrl(C_SRCA);
        alu_val = 32'h0;
        #1;
        chk("pre_rst.SrcA", SrcA, 32'hDEAD_BEEF);
        #1 reset = 1'b1;
        #1;
        $display("async reset: PC=%h Instr=%h SrcA=%h Adr=%h WriteData=%h", PC, Instr, SrcA, Adr, WriteData);
        chk("rst.PC", PC, 32'h0);
        chk("rst.Instr", Instr, 32'h0);
        chk("rst.A", SrcA, 32'h0);
        chk("rst.Adr", Adr, 32'h0);
        chk("rst.WriteData", WriteData, 32'h0);

        // Enables asserted while reset is held must not move state.
        drive_ctrl(C_PCW|C_IRW);
        ReadData = 32'h1234_5678;
        alu_val  = 32'h123;
        @(posedge clk);
        #1;
        $display("reset held: PC=%h Instr=%h", PC, Instr);
        chk("rst_hold.PC", PC, 32'h0);
        chk("rst_hold.Instr", Instr, 32'h0);

        // After release, read back $9 and $8, both cleared by reset.
        @(negedge clk);
        reset = 1'b0;
        drive_ctrl(C_IRW|C_SRCA);
        ReadData = 32'h0128_0000;
        alu_val  = 32'h0;
        @(posedge clk);
        #1;
        $display("post reset fetch: PC=%h Instr=%h", PC, Instr);
        chk("post.PC", PC, 32'h0);
        chk("post.Instr", Instr, 32'h0128_0000);
        @(negedge clk);
        drive_ctrl(C_SRCA);
        @(posedge clk);
        #1;
        $display("post reset read: SrcA=%h WriteData=%h", SrcA, WriteData);
        chk("post.r9", SrcA, 32'h0);
        chk("post.r8", WriteData, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_datapath_state.md
Name: mc_datapath_state

Overview:
- Architectural state and operand-steering stage of the multi-cycle MIPS core, directly downstream of main_decoder.
- Consumes the decoder's per-cycle control outputs and holds PC, IR, MDR, register file, the A/B operand registers and ALUOut.
- Drives the memory address and write data, and presents the ALU operands.
- The ALU itself is external and combinational. Its result and zero flag return to this block.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NREGS, 32, register file depth. Fixed at 32 and must not be overridden.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemtoReg  in  1  register-file write data select: 1 = MDR, 0 = ALUOut.
- RegDst  in  1  write register select: 1 = instr[15:11], 0 = instr[20:16].
- IorD  in  1  memory address select: 1 = ALUOut, 0 = PC.
- PCSrc  in  1  next-PC select: 1 = ALUOut, 0 = ALUResult.
- ALUSrcA  in  1  SrcA select: 1 = A, 0 = PC.
- ALUSrcB  in  2  SrcB select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- IRWrite  in  1  IR load enable.
- PCWrite  in  1  unconditional PC load.
- branch  in  1  conditional PC load, qualified by Zero.
- RegWrite  in  1  register file write enable.
- ALUResult  in  32  combinational ALU output.
- Zero  in  1  ALU zero flag.
- ReadData  in  32  memory read data.
- Adr  out  32  memory address.
- WriteData  out  32  memory write data; equals the B register.
- SrcA  out  32  ALU operand A.
- SrcB  out  32  ALU operand B.
- Instr  out  32  current IR contents.
- PC  out  32  current PC.

Behaviour:
- Reset:
  - Asserting reset, at any time including mid-instruction, immediately forces PC = RESET_PC.
  - IR, MDR, A, B, ALUOut and all 32 registers are forced to 0.
  - Outputs follow combinationally, e.g. Adr = RESET_PC when IorD = 0.
  - State holds while reset is high. The first update occurs on the first rising edge after deassertion.
- PC:
  - PCEn = PCWrite | (branch & Zero).
  - On an edge with PCEn = 1, PC <= (PCSrc ? ALUOut : ALUResult). Otherwise PC holds.
  - If PCWrite and branch are both 1, PC loads regardless of Zero.
- IR: IR <= ReadData only on edges where IRWrite = 1.
- Free-running registers, updated every edge with no enable:
  - MDR <= ReadData.
  - A <= RD1.
  - B <= RD2.
  - ALUOut <= ALUResult.
- Register file:
  - Read addresses: rs = IR[25:21], rt = IR[20:16].
  - RD1 and RD2 are combinational reads.
  - Reading register 0 always returns 0.
- Register write:
  - On an edge with RegWrite = 1 and a nonzero write address, reg[RegDst ? IR[15:11] : IR[20:16]] <= (MemtoReg ? MDR : ALUOut).
  - Writes to register 0 are discarded.
  - No write bypass: a read of the register being written in the same cycle returns the old value. A and B therefore capture the pre-write value on that edge.
- Immediate and operand muxes:
  - SignImm = {{16{IR[15]}}, IR[15:0]}.
  - SignImm<<2 shifts left by 2 with zero fill, and upper bits are truncated to 32.
  - SrcA, SrcB and Adr are purely combinational from current state and selects. Latency 0.
  - Constant 4 is 32'd4.
- Timing contract with the external ALU: ALUResult and Zero are sampled on the same edge as the PCEn decision. There is no internal pipelining beyond the registers listed above.
- Undefined or X control inputs must not corrupt state when their enables (IRWrite, PCWrite, branch, RegWrite) are 0.

Test Plan:
- Reset then fetch:
  - Pulse reset high for 5 ns. Check PC = 0, Adr = 0, Instr = 0.
  - Drive ReadData = 32'h2008_0005, IRWrite = 1, PCWrite = 1, ALUSrcA = 0, ALUSrcB = 01. The bench ALU computes SrcA+SrcB.
  - After one edge: Instr = 32'h2008_0005, PC = 4.
- Immediate path:
  - With Instr = 32'h2008_8000 and ALUSrcB = 10, check SrcB = 32'hFFFF_8000.
  - With ALUSrcB = 11, check SrcB = 32'hFFFE_0000.
- Register write and $0:
  - Set RegWrite = 1, RegDst = 0, MemtoReg = 0, ALUOut = 5, IR rt = 8. Next cycle, with IR rs = 8, A = 5.
  - Repeat with rt = 0. Reads of $0 must still return 0.
- Branch:
  - branch = 1, PCWrite = 0, PCSrc = 1, ALUOut = 32'h40, Zero = 1: PC = 32'h40.
  - Same with Zero = 0: PC unchanged.
  - PCWrite = 1 with branch = 1 and Zero = 0: PC loads.
- Memory access: with IorD = 1 and ALUOut = 32'h100, check Adr = 32'h100 and WriteData = B. With ReadData = 32'hDEAD_BEEF, MDR = 32'hDEAD_BEEF after one edge.
- Reset mid-operation: after PC = 32'h40 and a register has been written, assert reset between clock edges. PC, Instr and all register reads must be 0 immediately, before the next edge.
